// File: rtl/tieoff_and_pipe_pkg.sv
// Shared types for the tie-off AND pipeline: per-lane tie modes and sizing helpers.
// No logic, no latency, no flow control.
// Imported by tieoff_and_pipe and tieoff_stage.
package tieoff_pkg;

    typedef enum logic [1:0] {
        TIE_GND  = 2'd0,
        TIE_VCC  = 2'd1,
        TIE_DC   = 2'd2,
        TIE_PASS = 2'd3
    } tie_mode_t;

    localparam tie_mode_t TIE_MODE_RST = TIE_PASS;

    // Lane-index width, never narrower than one bit so WIDTH=1 still has a port.
    function automatic int lane_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tieoff_and_pipe_stage.sv
// One valid/ready register stage carrying a WIDTH-bit payload.
// Latency: 1 cycle.
// Backpressure: accepts when empty or when the downstream takes the held beat; payload is held while stalled.
module tieoff_stage
    import tieoff_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_ready
);

    logic             vld_q;
    logic [WIDTH-1:0] dat_q;
    logic             take;

    assign take = !vld_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (take) begin
            vld_q <= in_valid;
            if (in_valid) begin
                dat_q <= in_dat;
            end
        end
    end

    assign out_valid = vld_q;
    assign out_dat   = dat_q;

endmodule

// File: rtl/tieoff_and_pipe.sv
// Per-lane y = d & t with runtime GND/VCC/DC/PASS tie-offs; TIEOFF_DC_X_EN makes DC lanes drive X.
// Latency: DEPTH register stages from accept to out_valid; beat_cnt counts delivered beats, saturating.
// Backpressure: in_ready is combinational from out_ready through the stage chain, no skid buffer.
module tieoff_and_pipe
    import tieoff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [lane_w(WIDTH)-1:0]   cfg_lane,
    input  logic [1:0]                 cfg_mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           d,
    input  logic [WIDTH-1:0]           b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           y,
    output logic [CNT_W-1:0]           beat_cnt
);

    tie_mode_t        mode_q [WIDTH];
    logic [WIDTH-1:0] tie;
    logic [WIDTH-1:0] and_dat;

    // Out-of-range lane indices match no lane, so such writes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                mode_q[i] <= TIE_MODE_RST;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (32'(cfg_lane) == 32'(i)) begin
                    mode_q[i] <= tie_mode_t'(cfg_mode);
                end
            end
        end
    end

    always_comb begin
        tie = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode_q[i])
                TIE_GND:  tie[i] = 1'b0;
                TIE_VCC:  tie[i] = 1'b1;
`ifdef TIEOFF_DC_X_EN
                TIE_DC:   tie[i] = 1'bx;
`else
                TIE_DC:   tie[i] = 1'b0;
`endif
                TIE_PASS: tie[i] = b[i];
                default:  tie[i] = b[i];
            endcase
        end
    end

    assign and_dat = d & tie;

    // Index 0 is the input side; index k+1 is the output of stage k.
    logic [DEPTH:0]   stg_vld;
    logic [DEPTH:0]   stg_rdy;
    logic [WIDTH-1:0] stg_dat [DEPTH+1];

    assign stg_vld[0] = in_valid;
    assign stg_dat[0] = and_dat;

    // Stage k can take a beat if any stage from k onward is empty or the sink is ready.
    always_comb begin
        stg_rdy = '0;
        for (int k = 0; k <= DEPTH; k++) begin
            stg_rdy[k] = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!stg_vld[j+1]) begin
                    stg_rdy[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        tieoff_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (stg_vld[k]),
            .in_dat    (stg_dat[k]),
            .out_valid (stg_vld[k+1]),
            .out_dat   (stg_dat[k+1]),
            .out_ready (stg_rdy[k+1])
        );
    end

    assign in_ready  = stg_rdy[0];
    assign out_valid = stg_vld[DEPTH];
    assign y         = stg_dat[DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (out_valid && out_ready && (beat_cnt != {CNT_W{1'b1}})) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tieoff_and_pipe.sv
// Directed bench for tieoff_and_pipe: WIDTH=4, DEPTH=2, CNT_W=2.
module tb_tieoff_and_pipe;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_lane = '0;
    logic [1:0]       cfg_mode = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] d = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] beat_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    tieoff_and_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_lane  (cfg_lane),
        .cfg_mode  (cfg_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .beat_cnt  (beat_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input int lane, input logic [1:0] m);
        cfg_we   = 1'b1;
        cfg_lane = 2'(lane);
        cfg_mode = m;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_modes(input logic [3:0][1:0] m);
        for (int i = 0; i < WIDTH; i++) begin
            cfg_write(i, m[i]);
        end
    endtask

    // Offer one beat, then check it appears after two edges with the given value.
    task automatic beat_check(input string name, input logic [3:0] dv, input logic [3:0] bv,
                              input logic [3:0] exp);
        out_ready = 1'b1;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        d = dv;
        b = bv;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_lat1_vld"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, "_vld"}, 32'(out_valid), 32'd1);
        check({name, "_y"}, 32'(y), 32'(exp));
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0][1:0] modes;
        logic [3:0]      dv;
        logic [3:0]      bv;
        logic [3:0]      exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [3:0] dc_exp;
        logic [CNT_W-1:0] sat_exp [6];

`ifdef TIEOFF_DC_X_EN
        dc_exp = 4'b1x10;
`else
        dc_exp = 4'b1010;
`endif
        // modes packed as {lane3, lane2, lane1, lane0}
        vecs[0] = '{modes: {2'd3, 2'd2, 2'd1, 2'd0}, dv: 4'hF, bv: 4'h8, exp: dc_exp};
        vecs[1] = '{modes: {2'd3, 2'd3, 2'd3, 2'd3}, dv: 4'hF, bv: 4'h5, exp: 4'h5};
        vecs[2] = '{modes: {2'd1, 2'd1, 2'd1, 2'd1}, dv: 4'h6, bv: 4'h0, exp: 4'h6};
        vecs[3] = '{modes: {2'd0, 2'd0, 2'd0, 2'd0}, dv: 4'hF, bv: 4'hF, exp: 4'h0};
        vecs[4] = '{modes: {2'd0, 2'd1, 2'd3, 2'd3}, dv: 4'hC, bv: 4'h3, exp: 4'h4};
        vecs[5] = '{modes: {2'd1, 2'd3, 2'd1, 2'd2}, dv: 4'hA, bv: 4'hF, exp: 4'hA};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        // Reset values, both while held and after release
        @(negedge clk);
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        check("rst_hold_in_ready", 32'(in_ready), 32'd1);
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        beat_check("rst_modes_pass", 4'hF, 4'h9, 4'h9);

        for (int v = 0; v < 6; v++) begin
            set_modes(vecs[v].modes);
            beat_check($sformatf("vec%0d", v), vecs[v].dv, vecs[v].bv, vecs[v].exp);
        end

        // Config write colliding with an accept uses the old mode
        do_reset();
        set_modes({2'd1, 2'd1, 2'd1, 2'd1});
        in_valid = 1'b1; d = 4'hF; b = 4'h0;
        cfg_we = 1'b1; cfg_lane = 2'd1; cfg_mode = 2'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("coll_first_vld", 32'(out_valid), 32'd1);
        check("coll_first_y", 32'(y), 32'hF);
        @(negedge clk);
        check("coll_second_vld", 32'(out_valid), 32'd1);
        check("coll_second_y", 32'(y), 32'hD);
        @(negedge clk);

        // Backpressure: A, B fill the pipe, C waits, then all drain in order
        do_reset();
        set_modes({2'd3, 2'd3, 2'd3, 2'd3});
        out_ready = 1'b0;
        d = 4'hF;
        check("bp_a_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; b = 4'h1;
        @(negedge clk);
        check("bp_b_ready", 32'(in_ready), 32'd1);
        b = 4'h2;
        @(negedge clk);
        b = 4'h3;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_full_vld", 32'(out_valid), 32'd1);
        check("bp_full_y", 32'(y), 32'h1);
        @(negedge clk);
        check("bp_stall_ready", 32'(in_ready), 32'd0);
        check("bp_stall_y", 32'(y), 32'h1);
        check("bp_stall_cnt", 32'(beat_cnt), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_b_y", 32'(y), 32'h2);
        check("bp_cnt1", 32'(beat_cnt), 32'd1);
        @(negedge clk);
        check("bp_c_vld", 32'(out_valid), 32'd1);
        check("bp_c_y", 32'(y), 32'h3);
        check("bp_cnt2", 32'(beat_cnt), 32'd2);
        @(negedge clk);
        check("bp_empty_vld", 32'(out_valid), 32'd0);
        check("bp_cnt3", 32'(beat_cnt), 32'd3);

        // Counter saturation with a 2-bit counter over 6 back-to-back beats
        do_reset();
        out_ready = 1'b1;
        d = 4'hF;
        for (int c = 0; c < 9; c++) begin
            if (c >= 2 && c < 8) begin
                check($sformatf("sat_y%0d", c - 2), 32'(y), 32'(c - 2));
            end
            if (c >= 3) begin
                check($sformatf("sat_cnt%0d", c - 3), 32'(beat_cnt), 32'(sat_exp[c-3]));
            end
            in_valid = (c < 6);
            b = 4'(c);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Mid-stream reset discards in-flight beats and restores PASS modes
        do_reset();
        cfg_write(0, 2'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; d = 4'hF; b = 4'h7;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_pre_vld", 32'(out_valid), 32'd1);
        check("mr_pre_y", 32'(y), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_vld", 32'(out_valid), 32'd0);
        check("mr_async_ready", 32'(in_ready), 32'd1);
        check("mr_async_y", 32'(y), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("mr_no_stale%0d", c), 32'(out_valid), 32'd0);
        end
        check("mr_cnt", 32'(beat_cnt), 32'd0);
        beat_check("mr_modes_pass", 4'hF, 4'h3, 4'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
